// File: rtl/aes_block_controller_pkg.sv
// aes_block_controller_pkg
// Shared widths, command opcodes, the CBC flag position and the controller
// state encoding used by the AES block controller and its interface.
package aes_block_controller_pkg;

  localparam int BLK_S   = 128;  // block, key and IV width
  localparam int CMD_S   = 32;   // command word width
  localparam int WORD_S  = CMD_S;
  localparam int CBC_BIT = 2;

  localparam logic [1:0] OP_SET_KEY = 2'd0;
  localparam logic [1:0] OP_ENCRYPT = 2'd1;
  localparam logic [1:0] OP_DECRYPT = 2'd2;
  localparam logic [1:0] OP_RSVD    = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RDATA,
    ST_KEY,
    ST_IV,
    ST_START,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/aes_block_controller_if.sv
// aes_block_controller_if
// Bundles the command/status inputs from the AXI-Stream slave, both FIFO
// ports and the AES core strobe/data lines.
//   master : controller side (drives FIFO pop/push and core strobes)
//   slave  : environment side (FIFOs, AXI-Stream slave, AES core)
interface aes_block_controller_if;
  import aes_block_controller_pkg::*;

  logic [CMD_S-1:0] axis_cmd;
  logic             axis_slave_done;
  logic [BLK_S-1:0] in_fifo_rdata;
  logic             in_fifo_empty;
  logic             in_fifo_ready;
  logic             aes_controller_in_fifo_r_e;
  logic             aes_start;
  logic             aes_key_load;
  logic             aes_decrypt;
  logic [BLK_S-1:0] aes_din;
  logic             aes_done;
  logic [BLK_S-1:0] aes_dout;
  logic             out_fifo_full;
  logic             out_fifo_w_e;
  logic [BLK_S-1:0] out_fifo_wdata;
  logic             aes_controller_done;

  modport master (
    input  axis_cmd, axis_slave_done, in_fifo_rdata, in_fifo_empty,
           in_fifo_ready, aes_done, aes_dout, out_fifo_full,
    output aes_controller_in_fifo_r_e, aes_start, aes_key_load, aes_decrypt,
           aes_din, out_fifo_w_e, out_fifo_wdata, aes_controller_done
  );

  modport slave (
    output axis_cmd, axis_slave_done, in_fifo_rdata, in_fifo_empty,
           in_fifo_ready, aes_done, aes_dout, out_fifo_full,
    input  aes_controller_in_fifo_r_e, aes_start, aes_key_load, aes_decrypt,
           aes_din, out_fifo_w_e, out_fifo_wdata, aes_controller_done
  );

endinterface

// File: rtl/aes_block_controller.sv
// aes_block_controller
// Moves 128-bit blocks from the input FIFO through the AES core to the output
// FIFO, handling key load, IV load and CBC chaining, and pulses
// aes_controller_done once the slave has seen tlast and all blocks drained.
// Ports:
//   s00_axis_aclk    clock
//   s00_axis_aresetn synchronous active-low reset
//   bus              aes_block_controller_if.master (command, FIFOs, core)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a transfer; latches the command on first data
// FETCH   | pop one block when available, or finish when slave is done
// RDATA   | capture popped block and dispatch on the opcode
// KEY     | key-load strobe issued, waiting for core completion
// IV      | load chaining register from the block
// START   | compute core input, start strobe follows in WAIT
// WAIT    | waiting for core result
// WRITE   | push result once the output FIFO has room
// DONE    | end-of-transfer reported, waiting for slave_done to drop
module aes_block_controller
  import aes_block_controller_pkg::*;
(
  input logic                  s00_axis_aclk,
  input logic                  s00_axis_aresetn,
  aes_block_controller_if.master bus
);

  state_t           state_q, state_d;
  logic [CBC_BIT:0] cmd_q;
  logic [BLK_S-1:0] blk_q, res_q, chain_q, din_q;
  logic             iv_loaded_q, start_q, key_load_q, done_q;
  logic             r_e, w_e;
  logic [1:0]       op;
  logic             cbc;
  logic             unused_cmd_hi;

  // Only the opcode and CBC flag are meaningful; the rest of the word is ignored.
  assign unused_cmd_hi = ^bus.axis_cmd[CMD_S-1:CBC_BIT+1];

  assign op  = cmd_q[1:0];
  assign cbc = cmd_q[CBC_BIT];

  always_comb begin
    state_d = state_q;
    r_e     = 1'b0;
    w_e     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.in_fifo_empty)        state_d = ST_FETCH;
        else if (bus.axis_slave_done)  state_d = ST_DONE;
      end
      ST_FETCH: begin
        if (bus.in_fifo_ready && !bus.in_fifo_empty) begin
          r_e     = 1'b1;
          state_d = ST_RDATA;
        end else if (bus.in_fifo_empty && bus.axis_slave_done) begin
          state_d = ST_DONE;
        end
      end
      ST_RDATA: begin
        if (op == OP_SET_KEY)          state_d = ST_KEY;
        else if (op == OP_RSVD)        state_d = ST_FETCH;
        else if (cbc && !iv_loaded_q)  state_d = ST_IV;
        else                           state_d = ST_START;
      end
      ST_KEY:   if (bus.aes_done) state_d = ST_FETCH;
      ST_IV:    state_d = ST_FETCH;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (bus.aes_done) state_d = ST_WRITE;
      ST_WRITE: begin
        if (!bus.out_fifo_full) begin
          w_e     = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE:  if (!bus.axis_slave_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      blk_q       <= '0;
      res_q       <= '0;
      chain_q     <= '0;
      din_q       <= '0;
      iv_loaded_q <= 1'b0;
      start_q     <= 1'b0;
      key_load_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Strobes are registered so they line up with the registered din_q.
      start_q    <= (state_q == ST_START);
      key_load_q <= (state_q == ST_RDATA) && (state_d == ST_KEY);
      done_q     <= (state_q != ST_DONE) && (state_d == ST_DONE);
      case (state_q)
        ST_IDLE:  if (!bus.in_fifo_empty) cmd_q <= bus.axis_cmd[CBC_BIT:0];
        ST_RDATA: begin
          blk_q <= bus.in_fifo_rdata;
          if (state_d == ST_KEY) din_q <= bus.in_fifo_rdata;
        end
        ST_IV: begin
          chain_q     <= blk_q;
          iv_loaded_q <= 1'b1;
        end
        ST_START: din_q <= (cbc && op == OP_ENCRYPT) ? (blk_q ^ chain_q) : blk_q;
        ST_WAIT: begin
          if (bus.aes_done) begin
            if (cbc && op == OP_DECRYPT) begin
              res_q   <= bus.aes_dout ^ chain_q;
              chain_q <= blk_q;
            end else begin
              res_q <= bus.aes_dout;
              if (cbc) chain_q <= bus.aes_dout;
            end
          end
        end
        ST_DONE: begin
          // Chaining state is per transfer; the key lives in the core.
          if (!bus.axis_slave_done) begin
            iv_loaded_q <= 1'b0;
            chain_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.aes_controller_in_fifo_r_e = r_e;
  assign bus.aes_start                  = start_q;
  assign bus.aes_key_load               = key_load_q;
  assign bus.aes_decrypt                = (op == OP_DECRYPT);
  assign bus.aes_din                    = din_q;
  assign bus.out_fifo_w_e               = w_e;
  assign bus.out_fifo_wdata             = res_q;
  assign bus.aes_controller_done        = done_q;

endmodule
